// File: rtl/puf_uart_pkg.sv
// puf_uart_pkg: framing constants, error codes and parser state encoding shared by the UART command path
package puf_uart_pkg;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] CMD_EVAL      = 8'h01;
    localparam logic [7:0] CMD_PING      = 8'h02;
    localparam logic [1:0] ERR_CHK       = 2'd0;
    localparam logic [1:0] ERR_CMD       = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd2;
    localparam logic [1:0] ERR_OVR       = 2'd3;
    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_PAYLOAD, ST_CHECK, ST_ISSUE} parser_state_e;
endpackage

// File: rtl/puf_cmd_parser_if.sv
// puf_cmd_parser_if: UART byte stream in, challenge handshake and status strobes out
interface puf_cmd_parser_if #(parameter int CHAL_BYTES = 4);
    logic [7:0]              rx_data;
    logic                    rx_ready;
    logic                    chal_ready;
    logic                    chal_valid;
    logic [8*CHAL_BYTES-1:0] challenge;
    logic                    ping_req;
    logic                    frame_err;
    logic [1:0]              err_code;
    modport master (output rx_data, rx_ready, chal_ready,
                    input  chal_valid, challenge, ping_req, frame_err, err_code);
    modport slave  (input  rx_data, rx_ready, chal_ready,
                    output chal_valid, challenge, ping_req, frame_err, err_code);
endinterface

// File: rtl/frame_timeout_ctr.sv
// frame_timeout_ctr: idle-clock counter with clear priority and a one-cycle expire at LIMIT-1
module frame_timeout_ctr #(
    parameter int LIMIT = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(LIMIT + 1);
    logic [CW-1:0] cnt;
    // a byte in the same cycle clears and therefore masks the expiry
    assign expire = en && !clr && cnt == CW'(LIMIT - 1);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !expire) cnt <= cnt + 1'b1;
endmodule

// File: rtl/puf_cmd_parser.sv
// puf_cmd_parser: frames SYNC/CMD/payload/CHK host commands into PUF challenges and ping requests
module puf_cmd_parser
    import puf_uart_pkg::*;
#(
    parameter int         CHAL_BYTES   = 4,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CLKS = 50000
) (
    input logic                 clk,
    input logic                 reset_n,
    puf_cmd_parser_if.slave     bus
);
    localparam int W  = 8 * CHAL_BYTES;
    localparam int IW = CHAL_BYTES > 1 ? $clog2(CHAL_BYTES) : 1;
    parser_state_e state, state_d;
    logic [IW-1:0] idx, idx_d;
    logic [7:0]    acc, acc_d;
    logic          is_eval, is_eval_d;
    logic [W-1:0]  stage, stage_d, chal_d;
    logic          valid_d, ping_d, err_d, run, expire, rx, last;
    logic [1:0]    code_d;
    logic [7:0]    b;
    assign rx   = bus.rx_ready;
    assign b    = bus.rx_data;
    assign last = idx == IW'(CHAL_BYTES - 1);
    assign run  = state inside {ST_CMD, ST_PAYLOAD, ST_CHECK};
    frame_timeout_ctr #(.LIMIT(TIMEOUT_CLKS)) u_tmo (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (rx || !run),
        .en     (run),
        .expire (expire)
    );
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        acc_d     = acc;
        is_eval_d = is_eval;
        stage_d   = stage;
        chal_d    = bus.challenge;
        valid_d   = bus.chal_valid;
        ping_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = bus.err_code;
        case (state)
            ST_IDLE: state_d = rx && b == SYNC_BYTE ? ST_CMD : ST_IDLE;
            ST_CMD: if (rx) begin
                acc_d     = b;
                idx_d     = '0;
                is_eval_d = b == CMD_EVAL;
                state_d   = b == CMD_EVAL ? ST_PAYLOAD : b == CMD_PING ? ST_CHECK : ST_IDLE;
                err_d     = b != CMD_EVAL && b != CMD_PING;
                code_d    = err_d ? ERR_CMD : bus.err_code;
            end
            ST_PAYLOAD: if (rx) begin
                stage_d[idx*8 +: 8] = b;
                acc_d   = acc ^ b;
                idx_d   = last ? idx : idx + 1'b1;
                state_d = last ? ST_CHECK : ST_PAYLOAD;
            end
            ST_CHECK: if (rx) begin
                err_d   = b != acc;
                code_d  = err_d ? ERR_CHK : bus.err_code;
                ping_d  = !err_d && !is_eval;
                valid_d = !err_d && is_eval;
                chal_d  = valid_d ? stage : bus.challenge;
                state_d = valid_d ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: begin
                valid_d = !bus.chal_ready;
                state_d = bus.chal_ready ? ST_IDLE : ST_ISSUE;
                err_d   = rx;
                code_d  = rx ? ERR_OVR : bus.err_code;
            end
            default: state_d = ST_IDLE;
        endcase
        if (expire) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
        end
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            acc            <= '0;
            is_eval        <= 1'b0;
            stage          <= '0;
            bus.challenge  <= '0;
            bus.chal_valid <= 1'b0;
            bus.ping_req   <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.err_code   <= '0;
        end else begin
            state          <= state_d;
            idx            <= idx_d;
            acc            <= acc_d;
            is_eval        <= is_eval_d;
            stage          <= stage_d;
            bus.challenge  <= chal_d;
            bus.chal_valid <= valid_d;
            bus.ping_req   <= ping_d;
            bus.frame_err  <= err_d;
            bus.err_code   <= code_d;
        end
endmodule

// File: tb/tb_puf_cmd_parser.sv
// tb_puf_cmd_parser: scoreboard bench; expected challenges, pings and error codes are queued as frames are sent
module tb_puf_cmd_parser;
    localparam int EV_CHAL = 0, EV_PING = 1, EV_ERR = 2;
    typedef struct {int kind; logic [31:0] val;} ev_t;
    logic clk, reset_n, prev_valid;
    int   n_chk, n_fail;
    ev_t  q[$];
    puf_cmd_parser_if #(.CHAL_BYTES(4)) bus ();
    puf_cmd_parser #(.CHAL_BYTES(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(100)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    task automatic push(input int kind, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask
    task automatic expect_ev(input int kind, input logic [31:0] val, input string tag);
        ev_t e;
        if (q.size() == 0) check({tag, "_unexpected"}, 64'(q.size()), 64'd1);
        else begin
            e = q.pop_front();
            check({tag, "_kind"}, 64'(kind), 64'(e.kind));
            check({tag, "_value"}, 64'(val), 64'(e.val));
        end
    endtask
    always @(negedge clk) begin
        if (bus.frame_err) expect_ev(EV_ERR, {30'b0, bus.err_code}, "err");
        if (bus.ping_req) expect_ev(EV_PING, 32'd0, "ping");
        if (bus.chal_valid && !prev_valid) expect_ev(EV_CHAL, bus.challenge, "chal");
        prev_valid = bus.chal_valid;
    end
    task automatic send(input logic [7:0] v);
        bus.rx_data  = v;
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask
    task automatic send_eval(input logic [31:0] c, input bit good);
        logic [7:0] chk;
        chk = 8'h01;
        for (int i = 0; i < 4; i++) chk ^= c[8*i +: 8];
        if (!good) chk = ~chk;
        if (good) push(EV_CHAL, c);
        else push(EV_ERR, 32'd0);
        send(8'hA5);
        send(8'h01);
        for (int i = 0; i < 4; i++) send(c[8*i +: 8]);
        send(chk);
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(bus.chal_valid), 64'd0);
        check({tag, "_chal"}, 64'(bus.challenge), 64'd0);
        check({tag, "_err"}, 64'(bus.frame_err), 64'd0);
        check({tag, "_code"}, 64'(bus.err_code), 64'd0);
        check({tag, "_ping"}, 64'(bus.ping_req), 64'd0);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        int n;
        logic [31:0] held;
        n_chk = 0;
        n_fail = 0;
        prev_valid = 1'b0;
        reset_n = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_ready = 1'b0;
        bus.chal_ready = 1'b1;
        #1 check_zero("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_eval(32'h44332211, 1'b1);
        check("t1_valid_rise", 64'(bus.chal_valid), 64'd1);
        check("t1_err_quiet", 64'(bus.frame_err), 64'd0);
        @(negedge clk);
        check("t1_valid_1cyc", 64'(bus.chal_valid), 64'd0);
        send(8'h00); send(8'hFF); send(8'h13);
        push(EV_PING, 32'd0);
        send(8'hA5); send(8'h02); send(8'h02);
        check("ping_now", 64'(bus.ping_req), 64'd1);
        @(negedge clk);
        check("ping_1cyc", 64'(bus.ping_req), 64'd0);
        push(EV_ERR, 32'd0);
        send(8'hA5); send(8'h02); send(8'h03);
        check("ping_badchk_err", 64'(bus.frame_err), 64'd1);
        check("ping_badchk_noping", 64'(bus.ping_req), 64'd0);
        push(EV_ERR, 32'd1);
        send(8'hA5); send(8'h07);
        check("cmd_err_now", 64'(bus.frame_err), 64'd1);
        check("cmd_err_code", 64'(bus.err_code), 64'd1);
        send_eval(32'hDEADBEEF, 1'b1);
        @(negedge clk);
        send_eval(32'h01020304, 1'b0);
        check("badchk_chal_kept", 64'(bus.challenge), 64'hDEADBEEF);
        check("badchk_no_valid", 64'(bus.chal_valid), 64'd0);
        push(EV_ERR, 32'd2);
        send(8'hA5); send(8'h01); send(8'h11);
        n = 0;
        while (!bus.frame_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_clks", 64'(n), 64'd100);
        @(negedge clk);
        check("tmo_err_1cyc", 64'(bus.frame_err), 64'd0);
        push(EV_CHAL, 32'h44332211);
        send(8'hA5); send(8'h01); send(8'h11);
        repeat (99) @(negedge clk);
        check("late_byte_no_err", 64'(bus.frame_err), 64'd0);
        send(8'h22);
        check("late_byte_won", 64'(bus.frame_err), 64'd0);
        send(8'h33); send(8'h44); send(8'h45);
        check("late_frame_valid", 64'(bus.chal_valid), 64'd1);
        @(negedge clk);
        bus.chal_ready = 1'b0;
        held = 32'h89ABCDEF;
        send_eval(held, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                push(EV_ERR, 32'd3);
                send(8'h55);
                check("ovr_code", 64'(bus.err_code), 64'd3);
            end else @(negedge clk);
            check("hold_valid", 64'(bus.chal_valid), 64'd1);
            check("hold_chal", 64'(bus.challenge), 64'(held));
        end
        bus.chal_ready = 1'b1;
        @(negedge clk);
        check("hold_release", 64'(bus.chal_valid), 64'd0);
        bus.chal_ready = 1'b0;
        send_eval(32'h13572468, 1'b1);
        push(EV_ERR, 32'd3);
        send(8'h55);
        #3 reset_n = 1'b0;
        #1 check_zero("async_rst_issue");
        @(negedge clk);
        reset_n = 1'b1;
        bus.chal_ready = 1'b1;
        send(8'hA5); send(8'h01); send(8'h11);
        #3 reset_n = 1'b0;
        #1 check_zero("async_rst_payload");
        @(negedge clk);
        reset_n = 1'b1;
        send_eval(32'hA5A5A5A5, 1'b1);
        check("post_rst_valid", 64'(bus.chal_valid), 64'd1);
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("sb_drain", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
